btn_event_latch: RTL and testbench
==================================

Name: btn_event_latch

Overview:
- Input stage that feeds the button window (0xD000_0000 region) of the memory/IO bus decoder.
- Takes raw push-button pins, then synchronises, debounces and edge-detects them.
- Each press is held as a sticky event that the CPU reads exactly once. Read-to-clear semantics.
- Drives the decoder's btn_in / btn_en inputs.

Parameters:
- N_BTN, 6, number of buttons (matches the decoder's 6-bit btn_in).
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a level change; must be >= 2.
- CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_raw  input  N_BTN  raw asynchronous button pins, 1 = pressed
- rd_strobe  input  1  one-cycle pulse: CPU load from the 0xD region retires this cycle
- btn_in  output  N_BTN  pending press events (to decoder Cpu_data4bus path)
- btn_en  output  1  OR of btn_in; any event pending
- btn_level  output  N_BTN  debounced current button level
- overflow  output  1  sticky: a press arrived for a bit already pending

Behaviour:
- Reset (async, rst_n=0): sync flops, stable levels, counters, btn_in, btn_level, btn_en, overflow all 0. Release is sampled on the next clk rising edge. Reset mid-debounce discards the partial count.
- Sync:
  - 2-flop synchroniser per bit: s1 <= btn_raw, s2 <= s1.
  - A raw change set up before edge k appears on s2 after edge k+1.
- Debounce, per bit, counter cnt:
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to the stable value restarts the count from 0.
- Level output: btn_level = stable (registered). A clean raw change before edge k shows on btn_level after edge k+1+DEBOUNCE_CYCLES.
- Press detection:
  - press[i] = (accept event on bit i this cycle) && s2[i] == 1.
  - Release events produce nothing.
- Pending register, next state: btn_in <= (rd_strobe ? 0 : btn_in) | press.
  - Press and read in the same cycle: the read returns the old btn_in. The new press is retained, so it is never lost.
  - Multiple presses of one bit before a read collapse into a single event.
- overflow:
  - Set when press[i] && btn_in[i] && !rd_strobe, for any i.
  - Cleared only by rd_strobe, unless set again in that same cycle (set wins).
- btn_en: registered, equals |btn_in next state. It rises in the same cycle as btn_in.
- rd_strobe with btn_in = 0: no effect; overflow still clears.
- All outputs come straight from flops; there is no combinational path from input to output.

Decomposition:
- Shared package holds:
  - BTN_ADDR_NIBBLE = 4'hD.
  - N_BTN default 6.
  - DEBOUNCE_CYCLES default.
  - The simulation override constant DEBOUNCE_SIM = 4.
- One sub-module, btn_debounce:
  - Single-bit synchroniser, counter and stable flop; emits level and press pulse.
  - Instantiated N_BTN times via generate.
- Top level holds the pending, overflow and btn_en logic.

Test Plan:
- DEBOUNCE_CYCLES=4. Assert rst_n=0 for 3 cycles with btn_raw=6'h3F → all outputs 0. After release, btn_raw held at 3F → btn_level=3F and btn_in=3F exactly after edge 6 (k=1, 1+1+4); btn_en=1.
- Bounce: btn_raw[0] toggles 1,0,1,0 each cycle, then holds 1 → no event during toggling. btn_in=6'h01 exactly 5 edges after the final hold begins (2 sync + 4 count − 1 overlap checked against the formula).
- Read-to-clear: btn_in=6'h04, pulse rd_strobe → next cycle btn_in=0, btn_en=0. Holding the button pressed creates no new event. Release and press again → a new event.
- Simultaneous: btn_in=6'h01; the press on bit 1 is accepted in the same cycle as rd_strobe → btn_in=6'h02 afterwards, overflow=0.
- Overflow: btn_in[3]=1, second debounced press on bit 3 with no read → overflow=1, btn_in unchanged. rd_strobe → overflow=0, btn_in=0.
- Async reset mid-count: btn_raw[5]=1, pull rst_n low after 2 counted cycles (not on a clock edge) → outputs 0 immediately. After release, the full DEBOUNCE_CYCLES are required again.

Source files
------------

// File: rtl/btn_event_latch_pkg.sv
// btn_event_latch_pkg: shared constants for the button event latch
// Contents: button window address nibble, default sizing, simulation debounce override.
package btn_event_latch_pkg;
    localparam logic [3:0] BTN_ADDR_NIBBLE         = 4'hD;
    localparam int         N_BTN_DEFAULT           = 6;
    localparam int         DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int         DEBOUNCE_SIM            = 4;

    // True when a bus address falls in the button window.
    function automatic logic is_btn_addr(input logic [31:0] addr);
        return addr[31:28] == BTN_ADDR_NIBBLE;
    endfunction
endpackage

// File: rtl/btn_event_latch_if.sv
// btn_event_latch_if: CPU/decoder-side bus between the decoder and the button latch
// Signals: rd_strobe (read retires), btn_in (pending events), btn_en (any pending),
//          btn_level (debounced level), overflow (sticky lost-press flag).
// Modports: master = decoder/CPU side, slave = latch side.
interface btn_event_latch_if #(
    parameter int N_BTN = 6
);
    logic             rd_strobe;
    logic [N_BTN-1:0] btn_in;
    logic             btn_en;
    logic [N_BTN-1:0] btn_level;
    logic             overflow;

    modport master (output rd_strobe, input btn_in, btn_en, btn_level, overflow);
    modport slave  (input rd_strobe, output btn_in, btn_en, btn_level, overflow);
endinterface

// File: rtl/btn_event_latch_debounce.sv
// btn_event_latch_debounce: one-bit synchroniser, debounce counter and stable-level flop
// Ports: clk, rst_n (async active-low), i_raw (raw pin),
//        o_level (debounced level, registered), o_press (accepted 0->1 change this cycle).
module btn_event_latch_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);
    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;

    // Change is accepted once s2 has differed from the stable level for DEBOUNCE_CYCLES cycles.
    assign w_accept = (r_s2 != o_level) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign o_press  = w_accept && r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= '0;
            o_level <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == o_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                o_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/btn_event_latch.sv
// btn_event_latch: debounced push-button press events held sticky until read by the CPU
// Ports: clk, rst_n (async active-low), i_btn_raw (raw pins, 1 = pressed),
//        bus (slave side: rd_strobe in; btn_in, btn_en, btn_level, overflow out, all registered).
module btn_event_latch
    import btn_event_latch_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] i_btn_raw,
    btn_event_latch_if.slave bus
);
    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_pend_nxt;
    logic             w_ovf_set;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_event_latch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_raw  (i_btn_raw[g]),
            .o_level(w_level[g]),
            .o_press(w_press[g])
        );
    end

    // A read clears old events but a press in the same cycle survives into the new state.
    assign w_pend_nxt = (bus.rd_strobe ? '0 : bus.btn_in) | w_press;
    assign w_ovf_set  = |(w_press & bus.btn_in) && !bus.rd_strobe;
    assign bus.btn_level = w_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.btn_in   <= '0;
            bus.btn_en   <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            bus.btn_in   <= w_pend_nxt;
            bus.btn_en   <= |w_pend_nxt;
            bus.overflow <= w_ovf_set || (bus.overflow && !bus.rd_strobe);
        end
    end
endmodule

// File: tb/tb_btn_event_latch.sv
// tb_btn_event_latch: directed and randomized checks of btn_event_latch against a window-based model
module tb_btn_event_latch;
    import btn_event_latch_pkg::*;
    localparam int N = 6;
    localparam int D = DEBOUNCE_SIM;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] raw = '0;
    int           errors = 0;
    int           checks = 0;

    btn_event_latch_if #(.N_BTN(N)) bus ();

    btn_event_latch #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_btn_raw(raw),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a change is accepted when the last D synchronised samples all differ from the stable level.
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_pend = '0;
    logic         m_en = 1'b0, m_ovf = 1'b0;
    logic [N-1:0] m_hist [D];
    logic [N-1:0] m_acc, m_press;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0; m_en = 1'b0; m_ovf = 1'b0;
            for (int j = 0; j < D; j++) m_hist[j] = '0;
        end else begin
            for (int j = D - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = m_s2;
            m_acc = '1;
            for (int j = 0; j < D; j++) m_acc &= m_hist[j] ^ m_stable;
            m_press  = m_acc & m_s2;
            m_stable = m_stable ^ m_acc;
            m_ovf    = ((|(m_press & m_pend)) && !bus.rd_strobe) || (m_ovf && !bus.rd_strobe);
            m_pend   = (bus.rd_strobe ? '0 : m_pend) | m_press;
            m_en     = |m_pend;
            m_s2     = m_s1;
            m_s1     = raw;
        end
    end

    always @(negedge clk) begin
        chk("btn_in", 32'(bus.btn_in), 32'(m_pend));
        chk("btn_en", 32'(bus.btn_en), 32'(m_en));
        chk("btn_level", 32'(bus.btn_level), 32'(m_stable));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    end

    task automatic pulse_rd();
        bus.rd_strobe = 1'b1;
        @(negedge clk);
        bus.rd_strobe = 1'b0;
    endtask

    task automatic settle(input logic [N-1:0] v);
        raw = v;
        repeat (D + 4) @(negedge clk);
    endtask

    initial begin
        logic [3:0] bounce;
        bus.rd_strobe = 1'b0;
        raw   = 6'h3F;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in", 32'(bus.btn_in), 0);
        chk("rst_en", 32'(bus.btn_en), 0);
        chk("rst_level", 32'(bus.btn_level), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("start_level_early", 32'(bus.btn_level), 0);
        @(negedge clk);
        chk("start_level", 32'(bus.btn_level), 32'h3F);
        chk("start_in", 32'(bus.btn_in), 32'h3F);
        chk("start_en", 32'(bus.btn_en), 1);
        chk("model_start_in", 32'(m_pend), 32'h3F);
        pulse_rd();
        chk("clear_in", 32'(bus.btn_in), 0);
        chk("clear_en", 32'(bus.btn_en), 0);
        settle('0);

        bounce = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            raw = {5'b0, bounce[i]};
            @(negedge clk);
            chk("bounce_quiet", 32'(bus.btn_in), 0);
        end
        raw = 6'h01;
        repeat (5) @(negedge clk);
        chk("bounce_hold_early", 32'(bus.btn_in), 0);
        @(negedge clk);
        chk("bounce_hold", 32'(bus.btn_in), 32'h01);
        pulse_rd();
        settle('0);

        settle(6'h04);
        chk("r2c_press", 32'(bus.btn_in), 32'h04);
        pulse_rd();
        chk("r2c_in", 32'(bus.btn_in), 0);
        chk("r2c_en", 32'(bus.btn_en), 0);
        repeat (10) @(negedge clk);
        chk("r2c_hold", 32'(bus.btn_in), 0);
        settle('0);
        settle(6'h04);
        chk("r2c_again", 32'(bus.btn_in), 32'h04);
        pulse_rd();
        settle('0);

        settle(6'h01);
        chk("sim_pre", 32'(bus.btn_in), 32'h01);
        raw = 6'h03;
        repeat (5) @(negedge clk);
        bus.rd_strobe = 1'b1;
        @(negedge clk);
        bus.rd_strobe = 1'b0;
        chk("sim_in", 32'(bus.btn_in), 32'h02);
        chk("sim_ovf", 32'(bus.overflow), 0);
        pulse_rd();
        settle('0);

        settle(6'h08);
        settle('0);
        settle(6'h08);
        chk("ovf_set", 32'(bus.overflow), 1);
        chk("ovf_in", 32'(bus.btn_in), 32'h08);
        pulse_rd();
        chk("ovf_clr", 32'(bus.overflow), 0);
        chk("ovf_in_clr", 32'(bus.btn_in), 0);
        settle('0);

        settle(6'h10);
        raw = 6'h30;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in", 32'(bus.btn_in), 0);
        chk("arst_level", 32'(bus.btn_level), 0);
        chk("arst_en", 32'(bus.btn_en), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_level_early", 32'(bus.btn_level), 0);
        @(negedge clk);
        chk("arst_level_full", 32'(bus.btn_level), 32'h30);
        chk("arst_in_full", 32'(bus.btn_in), 32'h30);
        pulse_rd();

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) < (c < 1000 ? 1 : 3)) raw[$urandom_range(0, N - 1)] ^= 1'b1;
            bus.rd_strobe = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        bus.rd_strobe = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
